// File: rtl/strhw_common_types_pkg.sv
// Shared types for the strhw hash datapath: control-logic state, wide block/hash
// words, block geometry and the last-word byte mask.
package strhw_common_types;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [511:0] uint512;
  typedef logic [6:0]   uint7;

  localparam int unsigned BLOCK_BYTES     = 64;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned WORD_BYTES      = 8;

  // Keeps bytes [nbytes-1:0] of a word and zeroes the rest.
  function automatic logic [63:0] mask_bytes(input logic [63:0] word, input logic [3:0] nbytes);
    logic [63:0] m;
    m = '0;
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (4'(b) < nbytes) m[8*b +: 8] = word[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/strhw_block_feeder_word_packer.sv
// Writes one byte-masked 64-bit word into its slot of the 512-bit block buffer,
// optionally starting from an all-zero buffer.
module strhw_word_packer
  import strhw_common_types::*;
(
  input  uint512      buf_i,
  input  logic        clear_i,
  input  logic        wr_i,
  input  logic [2:0]  idx_i,
  input  logic [63:0] data_i,
  input  logic [3:0]  bytes_i,
  output uint512      buf_o
);

  always_comb begin
    buf_o = clear_i ? '0 : buf_i;
    for (int unsigned k = 0; k < WORDS_PER_BLOCK; k++) begin
      if (wr_i && (idx_i == 3'(k))) buf_o[64*k +: 64] = mask_bytes(data_i, bytes_i);
    end
  end

endmodule

// File: rtl/strhw_block_feeder.sv
// Packs a 64-bit word stream into 512-bit blocks, hands each block to the control
// logic over the trigger/state handshake and holds the finished hash for the host.
module strhw_block_feeder
  import strhw_common_types::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [63:0] s_data_i,
  input  logic        s_last_i,
  input  logic [3:0]  s_bytes_i,
  input  logic        hash_size_i,
  output logic        ctl_trg_o,
  input  state_t      ctl_state_i,
  output uint512      ctl_block_o,
  output uint7        ctl_block_size_o,
  output logic        ctl_hash_size_o,
  input  uint512      ctl_hash_i,
  output uint512      hash_o,
  output logic        hash_valid_o,
  input  logic        hash_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } fstate_e;

  fstate_e     state_q, state_d;
  logic [2:0]  wc_q, wc_d;
  uint512      buf_q, buf_d;
  uint7        bsize_q, bsize_d;
  logic        hsize_q, hsize_d;
  logic        pad_q, pad_d;
  logic        trg_q, trg_d;
  logic        ready_q, ready_d;
  uint512      hash_q, hash_d;
  logic        hvalid_q, hvalid_d;

  logic        accept;
  logic        buf_clear;
  logic [3:0]  nbytes;
  uint7        fill_bytes;

  assign accept     = s_valid_i && ready_q;
  assign nbytes     = !s_last_i ? 4'd8 : ((s_bytes_i > 4'd8) ? 4'd8 : s_bytes_i);
  assign fill_bytes = {1'b0, wc_q, 3'b000} + {3'b000, nbytes};

  strhw_word_packer u_packer (
    .buf_i   (buf_q),
    .clear_i (buf_clear),
    .wr_i    (accept),
    .idx_i   (wc_q),
    .data_i  (s_data_i),
    .bytes_i (nbytes),
    .buf_o   (buf_d)
  );

  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    bsize_d   = bsize_q;
    hsize_d   = hsize_q;
    pad_d     = pad_q;
    hash_d    = hash_q;
    buf_clear = 1'b0;
    unique case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          if (state_q == S_IDLE) hsize_d = hash_size_i;
          if (s_last_i || (wc_q == 3'd7)) begin
            state_d = S_ISSUE;
            wc_d    = '0;
            bsize_d = fill_bytes;
            pad_d   = s_last_i && (fill_bytes == 7'(BLOCK_BYTES));
          end else begin
            state_d = S_FILL;
            wc_d    = wc_q + 3'd1;
          end
        end
      end
      S_ISSUE: begin
        // Only a BUSY seen while our own trigger is up acknowledges this block.
        if (trg_q && (ctl_state_i == BUSY)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ctl_state_i == READY) begin
          buf_clear = 1'b1;
          wc_d      = '0;
          if (pad_q) begin
            state_d = S_ISSUE;
            bsize_d = '0;
            pad_d   = 1'b0;
          end else begin
            state_d = S_FILL;
          end
        end else if (ctl_state_i == DONE) begin
          buf_clear = 1'b1;
          hash_d    = ctl_hash_i;
          state_d   = S_RESULT;
        end
      end
      S_RESULT: begin
        if (hash_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    trg_d    = (state_d == S_ISSUE) && (ctl_state_i != BUSY);
    ready_d  = (state_d == S_IDLE) || (state_d == S_FILL);
    hvalid_d = (state_d == S_RESULT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      wc_q     <= '0;
      buf_q    <= '0;
      bsize_q  <= '0;
      hsize_q  <= 1'b0;
      pad_q    <= 1'b0;
      trg_q    <= 1'b0;
      ready_q  <= 1'b0;
      hash_q   <= '0;
      hvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      buf_q    <= buf_d;
      bsize_q  <= bsize_d;
      hsize_q  <= hsize_d;
      pad_q    <= pad_d;
      trg_q    <= trg_d;
      ready_q  <= ready_d;
      hash_q   <= hash_d;
      hvalid_q <= hvalid_d;
    end
  end

  assign s_ready_o        = ready_q;
  assign ctl_trg_o        = trg_q;
  assign ctl_block_o      = buf_q;
  assign ctl_block_size_o = bsize_q;
  assign ctl_hash_size_o  = hsize_q;
  assign hash_o           = hash_q;
  assign hash_valid_o     = hvalid_q;

endmodule

// File: tb/tb_strhw_block_feeder.sv
// Directed bench for strhw_block_feeder with a behavioural control-logic responder.
module tb_strhw_block_feeder;
  import strhw_common_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [3:0]  s_bytes = '0;
  logic        hash_size = 1'b0;
  logic        ctl_trg;
  state_t      ctl_state;
  uint512      ctl_block;
  uint7        ctl_block_size;
  logic        ctl_hash_size;
  uint512      ctl_hash;
  uint512      hash_out;
  logic        hash_valid;
  logic        hash_ready = 1'b0;

  uint512      cur_hash = '0;
  int          n_pass = 0;
  int          n_chk  = 0;

  strhw_block_feeder dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .s_valid_i        (s_valid),
    .s_ready_o        (s_ready),
    .s_data_i         (s_data),
    .s_last_i         (s_last),
    .s_bytes_i        (s_bytes),
    .hash_size_i      (hash_size),
    .ctl_trg_o        (ctl_trg),
    .ctl_state_i      (ctl_state),
    .ctl_block_o      (ctl_block),
    .ctl_block_size_o (ctl_block_size),
    .ctl_hash_size_o  (ctl_hash_size),
    .ctl_hash_i       (ctl_hash),
    .hash_o           (hash_out),
    .hash_valid_o     (hash_valid),
    .hash_ready_i     (hash_ready)
  );

  always #5 clk = ~clk;

  // Control-logic responder: takes a block on trigger, stays BUSY a few cycles,
  // then READY for full blocks or DONE for the short final block.
  state_t smp;
  int     bcnt;
  logic   fin;
  uint512 q_blk[$];
  uint7   q_sz[$];
  logic   q_hs[$];
  state_t q_from[$];

  assign ctl_hash = (ctl_state == DONE) ? cur_hash : {16{32'hDEAD_BEEF}};

  always @(posedge clk) begin
    smp = ctl_state;
    if (rst) begin
      ctl_state <= CLEAR;
      bcnt      <= 0;
      fin       <= 1'b0;
    end else if (ctl_state == BUSY) begin
      if (bcnt == 0) ctl_state <= fin ? DONE : READY;
      else bcnt <= bcnt - 1;
    end else if (ctl_trg) begin
      ctl_state <= BUSY;
      bcnt      <= 3;
      fin       <= (ctl_block_size < 7'd64);
      q_blk.push_back(ctl_block);
      q_sz.push_back(ctl_block_size);
      q_hs.push_back(ctl_hash_size);
      q_from.push_back(ctl_state);
    end
  end

  typedef struct {
    int             nbytes;
    logic [7:0]     seed;
    logic           hs;
    int             issues;
    logic [2:0][6:0] sz;
    int             hold;
    uint512         hash;
  } vec_t;

  vec_t tbl[7];
  logic fresh;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic uint512 exp_block(input int nbytes, input logic [7:0] seed, input int j);
    uint512 r;
    r = '0;
    for (int p = 0; p < 64; p++)
      if (64*j + p < nbytes) r[8*p +: 8] = seed - 8'(64*j + p);
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, s_ready, 1'b0);
    chk({tag, "_outs"}, {ctl_trg, ctl_block_size, ctl_hash_size, hash_valid}, '0);
    chk({tag, "_block"}, ctl_block, '0);
    chk({tag, "_hash"}, hash_out, '0);
  endtask

  task automatic send_msg(input int idx);
    int          nw, lastb, guard, pos;
    logic [63:0] d;
    uint512      abc;
    state_t      from_exp;
    logic        held_ok;
    nw    = (tbl[idx].nbytes == 0) ? 1 : (tbl[idx].nbytes + 7) / 8;
    lastb = tbl[idx].nbytes - 8 * (nw - 1);
    cur_hash = tbl[idx].hash;
    q_blk.delete(); q_sz.delete(); q_hs.delete(); q_from.delete();
    for (int w = 0; w < nw; w++) begin
      guard = 0;
      while (!s_ready && guard < 200) begin
        @(posedge clk); @(negedge clk);
        guard++;
        if (s_ready) chk("ready_after_READY", smp, READY);
      end
      if (!s_ready) begin
        chk("ready_timeout", s_ready, 1'b1);
        return;
      end
      for (int b = 0; b < 8; b++) begin
        pos = 8*w + b;
        d[8*b +: 8] = (pos < tbl[idx].nbytes) ? tbl[idx].seed - 8'(pos) : 8'hEE;
      end
      s_valid   = 1'b1;
      s_data    = d;
      s_last    = (w == nw - 1);
      s_bytes   = s_last ? 4'(lastb) : 4'd3;
      hash_size = (w == 0) ? tbl[idx].hs : ~tbl[idx].hs;
      @(posedge clk); @(negedge clk);
      s_valid = 1'b0;
      if (s_last || (w % 8 == 7)) begin
        chk("trg_next_cycle", ctl_trg, 1'b1);
        chk("ready_low_in_issue", s_ready, 1'b0);
      end
      s_last = 1'b0;
    end
    guard = 0;
    while (!hash_valid && guard < 400) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    chk("hash_valid_seen", hash_valid, 1'b1);
    chk("hash_valid_after_DONE", smp, DONE);
    chk("hash_value", hash_out, tbl[idx].hash);
    chk("issue_count", 32'(q_sz.size()), 32'(tbl[idx].issues));
    from_exp = fresh ? CLEAR : DONE;
    if (q_from.size() > 0) chk("first_issue_from", q_from[0], from_exp);
    for (int j = 0; j < q_sz.size() && j < 3; j++) begin
      chk("block_size", q_sz[j], tbl[idx].sz[j]);
      chk("block_data", q_blk[j], exp_block(tbl[idx].nbytes, tbl[idx].seed, j));
      chk("hash_size", q_hs[j], tbl[idx].hs);
    end
    if (tbl[idx].nbytes == 3 && q_blk.size() > 0) begin
      abc = 512'h626364;
      chk("abc_block", q_blk[0], abc);
    end
    held_ok = 1'b1;
    for (int h = 0; h < tbl[idx].hold; h++) begin
      @(posedge clk); @(negedge clk);
      if (!hash_valid || hash_out !== tbl[idx].hash) held_ok = 1'b0;
    end
    chk("hash_held", held_ok, 1'b1);
    hash_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    hash_ready = 1'b0;
    chk("ack_valid_low", hash_valid, 1'b0);
    chk("ack_ready_high", s_ready, 1'b1);
    fresh = 1'b0;
  endtask

  task automatic mid_reset();
    for (int w = 0; w < 3; w++) begin
      s_valid = 1'b1;
      s_data  = {8{8'h11}} + 64'(w);
      s_last  = 1'b0;
      s_bytes = 4'd8;
      @(posedge clk); @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_ready_after", s_ready, 1'b1);
    fresh = 1'b1;
  endtask

  initial begin
    tbl[0] = '{0,   8'h00, 1'b0, 1, {7'd0, 7'd0,  7'd0},  1, {16{32'hB6E6_B2F3}}};
    tbl[1] = '{3,   8'h64, 1'b1, 1, {7'd0, 7'd0,  7'd3},  1, {256'h0, {8{32'h4E2F_5A1D}}}};
    tbl[2] = '{64,  8'hA0, 1'b0, 2, {7'd0, 7'd0,  7'd64}, 1, {16{32'h1234_5678}}};
    tbl[3] = '{100, 8'h3C, 1'b1, 2, {7'd0, 7'd36, 7'd64}, 1, {16{32'h0F1E_2D3C}}};
    tbl[4] = '{20,  8'h10, 1'b0, 1, {7'd0, 7'd0,  7'd20}, 5, {16{32'hCAFE_F00D}}};
    tbl[5] = '{130, 8'hF0, 1'b1, 3, {7'd2, 7'd64, 7'd64}, 5, {16{32'h5A5A_0FF0}}};
    tbl[6] = '{8,   8'h55, 1'b0, 1, {7'd0, 7'd0,  7'd8},  1, {16{32'h7777_1111}}};
    fresh = 1'b1;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_reset", s_ready, 1'b1);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) mid_reset();
      send_msg(i);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
